// File: rtl/pc_opponent.sv
// Computer-opponent move engine: on each PC turn it picks an unshot cell on the
// player's board (LFSR seed plus linear probing), fires, and reports hit and sink.
module pc_opponent #(
    parameter int         ROWS      = 5,
    parameter int         COLS      = 5,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             state,
    input  logic [2:0]             boats_init,
    input  logic [ROWS*COLS*3-1:0] player_ship_id,
    output logic                   pc_mov,
    output logic                   pc_hit,
    output logic [2:0]             pc_row,
    output logic [2:0]             pc_col,
    output logic [2:0]             boats_player,
    output logic                   board_full
);

    localparam int         N        = ROWS * COLS;
    localparam logic [5:0] LAST     = 6'(N - 1);
    localparam logic [2:0] ST_START = 3'd0;
    localparam logic [2:0] ST_PC    = 3'd2;

    // state  | meaning
    // IDLE   | waiting for the rising edge of a PC turn
    // PICK   | seed the candidate from the LFSR, or report a full board
    // SEARCH | probe forward past already-shot cells
    // FIRE   | mark the cell shot and latch hit/row/col
    // UPDATE | sink check, boat count, pulse pc_mov
    // DONE   | wait for the PC turn to end
    typedef enum logic [2:0] {IDLE, PICK, SEARCH, FIRE, UPDATE, DONE} eng_t;

    eng_t         eng, eng_nxt;
    logic [63:0]  shot;
    logic [191:0] ids_pad;
    logic [7:0]   lfsr;
    logic [5:0]   cand;
    logic [2:0]   prev_state;
    logic [2:0]   cand_id;
    logic         sunk;
    logic         clear, do_pick, do_full, do_probe, do_fire, do_update;

    assign ids_pad = 192'(player_ship_id);
    assign cand_id = ids_pad[3*int'(cand) +: 3];

    // The just-fired cell is already marked, so a sunk ship has no unshot cell left.
    always_comb begin
        sunk = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (ids_pad[3*i +: 3] == cand_id && !shot[i]) sunk = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng        <= IDLE;
            prev_state <= ST_START;
        end else begin
            eng        <= eng_nxt;
            prev_state <= state;
        end
    end

    always_comb begin
        eng_nxt = eng;
        if (clear) begin
            eng_nxt = IDLE;
        end else begin
            case (eng)
                IDLE:    if (state == ST_PC && prev_state != ST_PC) eng_nxt = PICK;
                PICK:    eng_nxt = board_full ? DONE : SEARCH;
                SEARCH:  if (!shot[cand]) eng_nxt = FIRE;
                FIRE:    eng_nxt = UPDATE;
                UPDATE:  eng_nxt = DONE;
                DONE:    if (state != ST_PC) eng_nxt = IDLE;
                default: eng_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        clear     = (state == ST_START);
        do_pick   = (eng == PICK) && !board_full;
        do_full   = (eng == PICK) && board_full;
        do_probe  = (eng == SEARCH) && shot[cand];
        do_fire   = (eng == FIRE);
        do_update = (eng == UPDATE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shot         <= '0;
            lfsr         <= LFSR_SEED;
            cand         <= '0;
            pc_mov       <= 1'b0;
            pc_hit       <= 1'b0;
            pc_row       <= '0;
            pc_col       <= '0;
            boats_player <= '0;
            board_full   <= 1'b0;
        end else if (clear) begin
            shot         <= '0;
            boats_player <= boats_init;
            pc_hit       <= 1'b0;
            pc_mov       <= 1'b0;
            board_full   <= 1'b0;
        end else begin
            pc_mov     <= 1'b0;
            board_full <= &shot[N-1:0];
            if (do_pick) begin
                cand <= 6'(int'(lfsr) % N);
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
            if (do_full) begin
                pc_mov <= 1'b1;
                pc_hit <= 1'b0;
            end
            if (do_probe) cand <= (cand == LAST) ? 6'd0 : cand + 6'd1;
            if (do_fire) begin
                shot[cand] <= 1'b1;
                pc_hit     <= (cand_id != 3'd0);
                pc_row     <= 3'(int'(cand) / COLS);
                pc_col     <= 3'(int'(cand) % COLS);
            end
            if (do_update) begin
                pc_mov <= 1'b1;
                if (pc_hit && sunk && boats_player != 3'd0) boats_player <= boats_player - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_opponent.sv
// Bench for pc_opponent: a turn-level behavioural model checked every cycle,
// plus directed turns with hand-computed cells, latencies and boat counts.
module tb_pc_opponent;

    localparam logic [2:0] START = 3'd0, PLAY = 3'd1, PC = 3'd2, WIN = 3'd3;

    logic        clk, rst, sel;
    logic [2:0]  st, bi;
    logic [74:0] ids_a;
    logic [11:0] ids_b;
    logic [2:0]  st_a, st_b;

    logic       a_mov, a_hit, a_full, b_mov, b_hit, b_full;
    logic [2:0] a_row, a_col, a_boats, b_row, b_col, b_boats;
    logic       mov, hit, full;
    logic [2:0] row, col, boats;

    int n_cmp = 0;
    int n_fail = 0;

    assign st_a  = sel ? START : st;
    assign st_b  = sel ? st : START;
    assign mov   = sel ? b_mov   : a_mov;
    assign hit   = sel ? b_hit   : a_hit;
    assign full  = sel ? b_full  : a_full;
    assign row   = sel ? b_row   : a_row;
    assign col   = sel ? b_col   : a_col;
    assign boats = sel ? b_boats : a_boats;

    pc_opponent dut_a (
        .clk(clk), .rst(rst), .state(st_a), .boats_init(bi), .player_ship_id(ids_a),
        .pc_mov(a_mov), .pc_hit(a_hit), .pc_row(a_row), .pc_col(a_col),
        .boats_player(a_boats), .board_full(a_full));

    pc_opponent #(.ROWS(2), .COLS(2)) dut_b (
        .clk(clk), .rst(rst), .state(st_b), .boats_init(bi), .player_ship_id(ids_b),
        .pc_mov(b_mov), .pc_hit(b_hit), .pc_row(b_row), .pc_col(b_col),
        .boats_player(b_boats), .board_full(b_full));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- turn-level model ----------------
    int         mn, mcols;
    bit         m_shot [64];
    logic [7:0] m_lfsr;
    logic [2:0] m_prev;
    bit         m_busy, m_wait, m_full;
    int         m_k, m_fire_k, m_mov_k, m_cell;
    logic       exp_mov, exp_hit;
    logic [2:0] exp_row, exp_col, exp_boats;

    always_comb begin
        mn    = sel ? 4 : 25;
        mcols = sel ? 2 : 5;
    end

    function automatic logic [2:0] id_of(int i);
        return sel ? ids_b[3*i +: 3] : ids_a[3*i +: 3];
    endfunction

    function automatic bit all_shot();
        for (int i = 0; i < mn; i++) if (!m_shot[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int probes_from(int s);
        int c = s;
        for (int p = 0; p < mn; p++) begin
            if (!m_shot[c]) return p;
            c = (c + 1) % mn;
        end
        return 0;
    endfunction

    function automatic bit ship_sunk(logic [2:0] id);
        for (int i = 0; i < mn; i++) if (id_of(i) == id && !m_shot[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] lfsr_step(logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // A turn is resolved at its first PC edge; the pulse lands 4 edges later plus one per probe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) m_shot[i] <= 1'b0;
            m_lfsr <= 8'hA5; m_prev <= START; m_busy <= 1'b0; m_wait <= 1'b0; m_full <= 1'b0;
            m_k <= 0; m_fire_k <= 0; m_mov_k <= 0; m_cell <= 0;
            exp_mov <= 1'b0; exp_hit <= 1'b0; exp_row <= '0; exp_col <= '0; exp_boats <= '0;
        end else begin
            m_prev  <= st;
            exp_mov <= 1'b0;
            if (st == START) begin
                for (int i = 0; i < 64; i++) m_shot[i] <= 1'b0;
                exp_boats <= bi; exp_hit <= 1'b0; m_busy <= 1'b0; m_wait <= 1'b0;
            end else if (m_busy) begin
                m_k <= m_k + 1;
                if (!m_full && m_k == m_fire_k) begin
                    m_shot[m_cell] <= 1'b1;
                    exp_hit <= (id_of(m_cell) != 3'd0);
                    exp_row <= 3'(m_cell / mcols);
                    exp_col <= 3'(m_cell % mcols);
                end
                if (m_k == m_mov_k) begin
                    exp_mov <= 1'b1; m_busy <= 1'b0; m_wait <= 1'b1;
                    if (m_full) exp_hit <= 1'b0;
                    else if (exp_hit && ship_sunk(id_of(m_cell)) && exp_boats != 3'd0)
                        exp_boats <= exp_boats - 3'd1;
                end
            end else if (m_wait) begin
                if (st != PC) m_wait <= 1'b0;
            end else if (st == PC && m_prev != PC) begin
                m_busy <= 1'b1; m_k <= 1;
                if (all_shot()) begin
                    m_full <= 1'b1; m_mov_k <= 1;
                end else begin
                    m_full   <= 1'b0;
                    m_cell   <= (int'(m_lfsr) % mn + probes_from(int'(m_lfsr) % mn)) % mn;
                    m_fire_k <= 3 + probes_from(int'(m_lfsr) % mn);
                    m_mov_k  <= 4 + probes_from(int'(m_lfsr) % mn);
                    m_lfsr   <= lfsr_step(m_lfsr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_pc_mov", mov, exp_mov);
            check("cyc_pc_hit", hit, exp_hit);
            check("cyc_pc_row", row, exp_row);
            check("cyc_pc_col", col, exp_col);
            check("cyc_boats", boats, exp_boats);
            if (exp_mov) check("cyc_board_full", full, all_shot());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pc_turn(input string name, input int ek, input int er, input int ec,
                           input int eh, input int eb, input int ef);
        int k = -1;
        @(posedge clk); #2 st = PC;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (mov) begin k = i; break; end
        end
        check({name, "_latency"}, k, ek);
        check({name, "_row"}, row, er);
        check({name, "_col"}, col, ec);
        check({name, "_hit"}, hit, eh);
        check({name, "_boats"}, boats, eb);
        check({name, "_full"}, full, ef);
        @(posedge clk); #2 st = PLAY;
        repeat (3) @(posedge clk);
    endtask

    task automatic count_movs(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (mov) cnt++;
        end
    endtask

    task automatic do_reset(input logic s, input logic [2:0] b);
        #1 rst = 1'b1;
        sel = s; st = START; bi = b;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 st = PLAY;
    endtask

    initial begin
        int cnt;
        rst = 1'b0; sel = 1'b0; st = START; bi = 3'd3; ids_a = '0; ids_b = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_mov", a_mov, 0);   check("rst_hit", a_hit, 0);
        check("rst_row", a_row, 0);   check("rst_col", a_col, 0);
        check("rst_boats", a_boats, 0); check("rst_full", a_full, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("init_boats", boats, 3);
        #1 st = PLAY;

        // first move from seed A5 lands on cell 15, all water
        pc_turn("miss", 4, 3, 0, 0, 3, 0);
        st = WIN;
        count_movs(8, cnt);
        check("win_no_move", cnt, 0);
        st = PLAY;

        // ship 1 at cells 15,16; ship 2 at cell 24
        ids_a[45 +: 3] = 3'd1; ids_a[48 +: 3] = 3'd1; ids_a[72 +: 3] = 3'd2;
        do_reset(1'b0, 3'd2);
        pc_turn("hit15", 4, 3, 0, 1, 2, 0);
        pc_turn("sink24", 4, 4, 4, 1, 1, 0);
        pc_turn("wrap0", 5, 0, 0, 0, 1, 0);

        // abort during SEARCH: no pulse, boat count reloaded
        @(posedge clk); #2 st = PC;
        repeat (2) @(posedge clk);
        #2 st = START;
        count_movs(10, cnt);
        check("abort_no_move", cnt, 0);
        check("abort_boats", boats, 2);
        st = PLAY;
        pc_turn("after_abort", 4, 1, 4, 0, 2, 0);

        // async reset while the engine sits in FIRE
        @(posedge clk); #2 st = PC;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstfire_mov", a_mov, 0);   check("rstfire_hit", a_hit, 0);
        check("rstfire_row", a_row, 0);   check("rstfire_col", a_col, 0);
        check("rstfire_boats", a_boats, 0); check("rstfire_full", a_full, 0);
        st = START;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 st = PLAY;
        @(posedge clk); #2 st = PC;
        count_movs(20, cnt);
        check("hold_one_move", cnt, 1);
        check("hold_row", row, 3);
        check("hold_col", col, 0);
        check("hold_hit", hit, 1);
        st = PLAY;
        repeat (3) @(posedge clk);

        // 2x2 board, ship 1 at cell 3
        ids_b[9 +: 3] = 3'd1;
        do_reset(1'b1, 3'd1);
        pc_turn("b_t1", 4, 0, 1, 0, 1, 0);
        pc_turn("b_t2", 4, 1, 0, 0, 1, 0);
        pc_turn("b_t3", 6, 1, 1, 1, 0, 0);
        pc_turn("b_t4", 6, 0, 0, 0, 0, 1);
        pc_turn("b_full", 1, 0, 0, 0, 0, 1);
        st = START;
        repeat (3) @(posedge clk);
        #1 check("b_clear_boats", boats, 1);
        st = PLAY;
        pc_turn("b_t6", 4, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
